// File: rtl/me_pkg.sv
// Shared definitions for the full-search motion-estimation control unit.
//   - me_state_t   : main sequencer states
//   - DEF_*        : default geometry used when the top is not overridden
//   - helper functions deriving candidate count, centre offset and the
//     lengths of the three enable windows from the window/block geometry
package me_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_ACK
    } me_state_t;

    localparam int DEF_SAD_WIDTH = 16;
    localparam int DEF_TB_LENGTH = 16;
    localparam int DEF_SW_LENGTH = 64;

    // Number of template placements inside the search window.
    function automatic int ncand(input int sw, input int tb);
        return (sw - tb + 1) * (sw - tb + 1);
    endfunction

    // Placement index that corresponds to a zero motion vector.
    function automatic int centre_off(input int sw, input int tb);
        return (sw - tb) / 2;
    endfunction

    // Enable window lengths, all measured from the first RUN cycle.
    function automatic int addr_sw_len(input int sw);
        return sw * sw;
    endfunction

    function automatic int addr_tb_len(input int tb);
        return tb * tb;
    endfunction

    function automatic int pe_sw_len(input int sw, input int tb);
        return sw * sw + sw - tb;
    endfunction

endpackage

// File: rtl/me_enable_window.sv
// Single enable pulse train: while run is high, en is asserted on RUN
// cycles START .. START+LEN-1 (cycle 0 = first cycle with run high).
// The counter restarts whenever run drops and saturates past the window.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : sequencer is in its scan state
//   en         : enable output
module me_enable_window #(
    parameter int START = 0,
    parameter int LEN   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic en
);

    localparam int STOP = START + LEN;
    localparam int CW   = $clog2(STOP + 1);
    localparam logic [CW-1:0] START_C = CW'(START);
    localparam logic [CW-1:0] STOP_C  = CW'(STOP);

    logic [CW-1:0] cnt;
    logic          in_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt != STOP_C) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A window opening at cycle 0 needs no lower-bound compare.
    if (START == 0) begin : g_from_zero
        assign in_win = (cnt < STOP_C);
    end else begin : g_from_start
        assign in_win = (cnt >= START_C) && (cnt < STOP_C);
    end

    assign en = run && in_win;

endmodule

// File: rtl/me_ctrl_fs_param.sv
// Full-search motion-estimation control unit. Sequences the SW/TB address
// generators and PE-array enables, scans all candidate positions, keeps the
// minimum SAD and reports its signed motion vector relative to the window
// centre. Supports early termination on a SAD threshold and a software abort.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req / ack           : 4-phase search handshake
//   abort               : pulse, abandon the current search
//   early_en/sad_thresh : early termination control, captured at RUN entry
//   sad                 : PE-array SAD for the current scan position
//   clr                 : accumulator clear (IDLE)
//   en_addr_sw/tb       : address generator enables
//   en_pearray_sw/tb    : PE-array shift / load enables
//   min_sad/min_cnt     : best SAD and its candidate index
//   min_mvx/min_mvy     : signed motion vector of the best SAD
//   cand_cnt            : candidates evaluated
//   early               : result came from early termination
module me_ctrl_fs_param
    import me_pkg::*;
#(
    parameter int SAD_WIDTH  = DEF_SAD_WIDTH,
    parameter int TB_LENGTH  = DEF_TB_LENGTH,
    parameter int SW_LENGTH  = DEF_SW_LENGTH,
    parameter int PE_LATENCY = SW_LENGTH - TB_LENGTH + 7,
    parameter int NCAND      = ncand(SW_LENGTH, TB_LENGTH),
    parameter int CNT_WIDTH  = $clog2(NCAND + 1),
    parameter int VEC_WIDTH  = $clog2(SW_LENGTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req,
    input  logic                        abort,
    input  logic                        early_en,
    input  logic [SAD_WIDTH-1:0]        sad_thresh,
    input  logic [SAD_WIDTH-1:0]        sad,
    output logic                        clr,
    output logic                        en_addr_sw,
    output logic                        en_addr_tb,
    output logic                        en_pearray_sw,
    output logic                        en_pearray_tb,
    output logic [SAD_WIDTH-1:0]        min_sad,
    output logic [CNT_WIDTH-1:0]        min_cnt,
    output logic signed [VEC_WIDTH-1:0] min_mvx,
    output logic signed [VEC_WIDTH-1:0] min_mvy,
    output logic [CNT_WIDTH-1:0]        cand_cnt,
    output logic                        early,
    output logic                        ack
);

    localparam int XY_W  = $clog2(SW_LENGTH);
    localparam int LAT_W = $clog2(PE_LATENCY + 2);
    localparam logic [XY_W-1:0]      XY_MAX  = XY_W'(SW_LENGTH - 1);
    localparam logic [XY_W-1:0]      TB_M1   = XY_W'(TB_LENGTH - 1);
    localparam logic [LAT_W-1:0]     LAT_C   = LAT_W'(PE_LATENCY);
    localparam logic [CNT_WIDTH-1:0] NCAND_C = CNT_WIDTH'(NCAND);
    localparam logic signed [VEC_WIDTH-1:0] MV_BIAS =
        VEC_WIDTH'(TB_LENGTH - 1 + centre_off(SW_LENGTH, TB_LENGTH));

    // Scan coordinate -> signed vector component about the window centre.
    function automatic logic signed [VEC_WIDTH-1:0] to_mv(input logic [XY_W-1:0] p);
        return $signed(VEC_WIDTH'(p)) - MV_BIAS;
    endfunction

    me_state_t            state, state_nxt;
    logic                 run;
    logic                 drain_cnt;
    logic [LAT_W-1:0]     lat_cnt;
    logic [XY_W-1:0]      x, y;
    logic                 early_en_q;
    logic [SAD_WIDTH-1:0] thresh_q;
    logic                 en_addr_tb_p1;
    logic                 scan_on, last_pos, valid, early_hit, take, better;

    assign run = (state == ST_RUN);

    assign scan_on   = run && (lat_cnt == LAT_C);
    assign last_pos  = scan_on && (x == XY_MAX) && (y == XY_MAX);
    assign valid     = scan_on && (x >= TB_M1) && (y >= TB_M1);
    assign early_hit = valid && early_en_q && (sad <= thresh_q);
    // An abort freezes results unless an early hit lands in the same cycle.
    assign take      = valid && (!abort || early_hit) && (cand_cnt != NCAND_C);
    assign better    = take && (sad < min_sad);

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        ack       = 1'b0;
        case (state)
            ST_INIT:  state_nxt = ST_IDLE;
            ST_IDLE: begin
                clr = 1'b1;
                if (req) state_nxt = ST_RUN;
            end
            ST_RUN:   if (last_pos || early_hit || abort) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt) state_nxt = ST_ACK;
            ST_ACK: begin
                ack = 1'b1;
                if (!req) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // Early-termination settings are frozen for the whole search.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            early_en_q <= early_en;
            thresh_q   <= sad_thresh;
        end
    end

    // Scan position: latency countdown, then y inner / x outer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= '0;
            x       <= '0;
            y       <= '0;
        end else if (!run) begin
            lat_cnt <= '0;
            x       <= '0;
            y       <= '0;
        end else if (lat_cnt != LAT_C) begin
            lat_cnt <= lat_cnt + 1'b1;
        end else if (y == XY_MAX) begin
            y <= '0;
            x <= x + 1'b1;
        end else begin
            y <= y + 1'b1;
        end
    end

    // Results clear on every entry into (and stay in) IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_sad  <= '1;
            min_cnt  <= '0;
            min_mvx  <= '0;
            min_mvy  <= '0;
            cand_cnt <= '0;
            early    <= 1'b0;
        end else if (state_nxt == ST_IDLE) begin
            min_sad  <= '1;
            min_cnt  <= '0;
            min_mvx  <= '0;
            min_mvy  <= '0;
            cand_cnt <= '0;
            early    <= 1'b0;
        end else begin
            if (take) cand_cnt <= cand_cnt + 1'b1;
            if (better) begin
                min_sad <= sad;
                min_cnt <= cand_cnt;
                min_mvx <= to_mv(x);
                min_mvy <= to_mv(y);
            end
            if (early_hit) early <= 1'b1;
        end
    end

    me_enable_window #(.START(0), .LEN(addr_sw_len(SW_LENGTH))) u_addr_sw (
        .clk(clk), .rst_n(rst_n), .run(run), .en(en_addr_sw)
    );

    me_enable_window #(.START(0), .LEN(addr_tb_len(TB_LENGTH))) u_addr_tb (
        .clk(clk), .rst_n(rst_n), .run(run), .en(en_addr_tb)
    );

    me_enable_window #(.START(1), .LEN(pe_sw_len(SW_LENGTH, TB_LENGTH))) u_pearray_sw (
        .clk(clk), .rst_n(rst_n), .run(run), .en(en_pearray_sw)
    );

    // TB load follows the TB address by one cycle; gated so DRAIN stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_addr_tb_p1 <= 1'b0;
        else        en_addr_tb_p1 <= en_addr_tb;
    end

    assign en_pearray_tb = en_addr_tb_p1 && run;

endmodule
